// File: rtl/order_fetch_cache.sv
// Direct-mapped read-only instruction cache for the 023A fetch path.
// Serves the core's order_* handshake and refills whole lines over a word-wide req/ack bus.
module order_fetch_cache #(
  parameter int LINE_NUM   = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] order_address,
  output logic [31:0] order_bus,
  output logic        order_read_cplt,
  input  logic        flush,
  output logic [31:0] mem_addr,
  output logic        mem_req,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int OB = $clog2(LINE_WORDS);
  localparam int IB = $clog2(LINE_NUM);
  localparam int TW = 32 - 2 - OB - IB;

  typedef enum logic [1:0] {IDLE, COMPARE, REFILL, RESP} state_t;

  state_t            state;
  logic [31:0]       req_addr;
  logic [OB-1:0]     wc;
  logic [OB-1:0]     wc_next;
  logic              flush_pend;
  logic [LINE_NUM-1:0] valid;

  logic [31:0]       data_mem [LINE_NUM*LINE_WORDS];
  logic [TW-1:0]     tag_mem  [LINE_NUM];

  logic [OB-1:0]     req_word;
  logic [IB-1:0]     req_index;
  logic [TW-1:0]     req_tag;
  logic              hit;
  logic              last_word;

  always_comb begin
    req_word  = req_addr[2+OB-1:2];
    req_index = req_addr[2+OB+IB-1:2+OB];
    req_tag   = req_addr[31:2+OB+IB];
    hit       = valid[req_index] && (tag_mem[req_index] == req_tag);
    last_word = (wc == OB'(LINE_WORDS - 1));
    wc_next   = wc + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      req_addr        <= '0;
      wc              <= '0;
      flush_pend      <= 1'b0;
      valid           <= '0;
      order_bus       <= '0;
      order_read_cplt <= 1'b0;
      mem_req         <= 1'b0;
      mem_addr        <= '0;
      hit_cnt         <= '0;
      miss_cnt        <= '0;
    end else begin
      order_read_cplt <= 1'b0;
      if (flush)
        valid <= '0;
      case (state)
        IDLE: begin
          req_addr <= order_address;
          state    <= COMPARE;
        end
        COMPARE: begin
          if (order_address != req_addr) begin
            req_addr <= order_address;
          end else if (hit) begin
            order_bus       <= data_mem[{req_index, req_word}];
            order_read_cplt <= 1'b1;
            state           <= RESP;
            if (hit_cnt != '1)
              hit_cnt <= hit_cnt + 32'd1;
          end else begin
            state      <= REFILL;
            wc         <= '0;
            flush_pend <= 1'b0;
            mem_req    <= 1'b1;
            mem_addr   <= {req_tag, req_index, {OB{1'b0}}, 2'b00};
            if (miss_cnt != '1)
              miss_cnt <= miss_cnt + 32'd1;
          end
        end
        REFILL: begin
          // A flush seen at any point of the refill keeps the finished line invalid.
          if (flush)
            flush_pend <= 1'b1;
          if (mem_ack) begin
            wc <= wc_next;
            if (last_word) begin
              mem_req <= 1'b0;
              state   <= COMPARE;
              if (!flush && !flush_pend)
                valid[req_index] <= 1'b1;
            end else begin
              mem_addr <= {req_tag, req_index, wc_next, 2'b00};
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == REFILL && mem_ack) begin
      data_mem[{req_index, wc}] <= mem_rdata;
      if (last_word)
        tag_mem[req_index] <= req_tag;
    end
  end

endmodule

// File: tb/tb_order_fetch_cache.sv
// Directed bench for order_fetch_cache: cold miss, hits, conflict, redirect, flush, async reset.
module tb_order_fetch_cache;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] order_address;
  logic [31:0] order_bus;
  logic        order_read_cplt;
  logic        flush;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int total = 0;
  int bad   = 0;
  int base;
  logic [31:0] log_q [$];

  order_fetch_cache #(
    .LINE_NUM  (16),
    .LINE_WORDS(4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .order_address  (order_address),
    .order_bus      (order_bus),
    .order_read_cplt(order_read_cplt),
    .flush          (flush),
    .mem_addr       (mem_addr),
    .mem_req        (mem_req),
    .mem_rdata      (mem_rdata),
    .mem_ack        (mem_ack),
    .hit_cnt        (hit_cnt),
    .miss_cnt       (miss_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    case (a)
      32'h100: mdata = 32'h11;
      32'h104: mdata = 32'h22;
      32'h108: mdata = 32'h33;
      32'h10C: mdata = 32'h44;
      default: mdata = {16'hD000, a[15:0]};
    endcase
  endfunction

  // Memory answers every request in the cycle it is seen; each acked address is logged.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack   = mem_req;
      mem_rdata = mdata(mem_addr);
      if (mem_req)
        log_q.push_back(mem_addr);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] redir,
                       input int flush_lat, input logic [31:0] exp_data, input int exp_lat);
    int lat = 0;
    bit ok  = 1'b0;
    order_address = a;
    while (!ok && lat < 100) begin
      @(negedge clk);
      lat++;
      if (order_read_cplt) begin
        ok = 1'b1;
      end else begin
        if (lat == 1 && redir != 0)
          order_address = redir;
        flush = (lat == flush_lat);
      end
    end
    flush = 1'b0;
    check({tag, "_done"}, 32'(ok), 32'd1);
    check({tag, "_data"}, order_bus, exp_data);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    @(negedge clk);
  endtask

  initial begin
    rst_n         = 1'b0;
    order_address = '0;
    flush         = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cplt", 32'(order_read_cplt), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_bus", order_bus, 32'h0);
    check("rst_hit", hit_cnt, 32'd0);
    check("rst_miss", miss_cnt, 32'd0);
    rst_n = 1'b1;

    base = log_q.size();
    fetch("cold", 32'h100, 32'h0, -1, 32'h11, 7);
    check("cold_nreq", 32'(log_q.size() - base), 32'd4);
    for (int i = 0; i < 4; i++)
      check("cold_maddr", log_q[base+i], 32'h100 + 32'(4*i));
    check("cold_miss", miss_cnt, 32'd1);
    check("cold_hit", hit_cnt, 32'd1);

    base = log_q.size();
    fetch("hit1", 32'h104, 32'h0, -1, 32'h22, 2);
    fetch("hit2", 32'h10C, 32'h0, -1, 32'h44, 2);
    check("hit_nreq", 32'(log_q.size() - base), 32'd0);
    check("hit_hit", hit_cnt, 32'd3);
    check("hit_miss", miss_cnt, 32'd1);

    base = log_q.size();
    fetch("confa", 32'h200, 32'h0, -1, 32'hD000_0200, 7);
    check("confa_m0", log_q[base], 32'h200);
    check("confa_m3", log_q[base+3], 32'h20C);
    fetch("confb", 32'h100, 32'h0, -1, 32'h11, 7);
    check("conf_miss", miss_cnt, 32'd3);
    check("conf_hit", hit_cnt, 32'd5);

    base = log_q.size();
    fetch("redir", 32'h100, 32'h140, -1, 32'hD000_0140, 8);
    check("redir_m0", log_q[base], 32'h140);
    check("redir_miss", miss_cnt, 32'd4);
    check("redir_hit", hit_cnt, 32'd6);

    base = log_q.size();
    fetch("flush", 32'h300, 32'h0, 4, 32'hD000_0300, 12);
    check("flush_nreq", 32'(log_q.size() - base), 32'd8);
    check("flush_m3", log_q[base+3], 32'h30C);
    check("flush_m4", log_q[base+4], 32'h300);
    check("flush_miss", miss_cnt, 32'd6);
    check("flush_hit", hit_cnt, 32'd7);

    order_address = 32'h180;
    repeat (3) @(negedge clk);
    check("arst_pre_req", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_req", 32'(mem_req), 32'd0);
    check("arst_cplt", 32'(order_read_cplt), 32'd0);
    check("arst_hit", hit_cnt, 32'd0);
    check("arst_miss", miss_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    fetch("post", 32'h100, 32'h0, -1, 32'h11, 7);
    check("post_miss", miss_cnt, 32'd1);
    check("post_hit", hit_cnt, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
